// File: rtl/dram_responder.sv
// Line-organised DRAM model for the L1 cache request port: one request per
// handshake, fixed access latency, then a one-cycle registered acknowledge.
//
// state  | meaning
// S_IDLE | waiting for mem_cs; request is latched on the accepting edge
// S_BUSY | latency countdown; request inputs ignored
// S_ACK  | mem_ack high for one cycle, then back to S_IDLE
module dram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LINE_W  = 128,
  parameter int LATENCY = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_cs,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_busy
);

  localparam logic [7:0] LP_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;
  logic              r_ack;
  logic [LINE_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic              w_accept;
  logic              w_done;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_wdata;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_cs) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next = S_ACK;
            w_done = 1'b1;
          end else begin
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt <= 8'd1) begin
          w_next = S_ACK;
          w_done = 1'b1;
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access completes on the accepting edge, so the live inputs are used.
  assign w_we    = (r_state == S_IDLE) ? mem_we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? mem_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_done;
      if (w_accept) begin
        r_cnt   <= LP_LOAD;
        r_we    <= mem_we;
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end else if (r_state == S_BUSY && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_done && !w_we) r_rdata <= r_mem[w_addr];
    end
  end

  // Storage has no reset; a write reaching its completion edge together with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_done && w_we) r_mem[w_addr] <= w_wdata;
  end

  assign mem_rdata = r_rdata;
  assign mem_ack   = r_ack;
  assign mem_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: a 10-cycle and a 1-cycle instance checked against
// a line-array model with per-cycle busy/ack/rdata expectations.
module tb_dram_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         cs0, cs1;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] rdata0, rdata1;
  logic         ack0, ack1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  logic [127:0] mdl [2][1024];
  logic [127:0] last_rd [2];
  logic [9:0]   pool [$];

  always #5 clk = ~clk;

  dram_responder #(.ADDR_W(10), .LINE_W(128), .LATENCY(10)) u_dut0 (
    .clk(clk), .rst(rst), .mem_cs(cs0), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata0), .mem_ack(ack0), .mem_busy(busy0));

  dram_responder #(.ADDR_W(10), .LINE_W(128), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_cs(cs1), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_ack(ack1), .mem_busy(busy1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cs(input int inst, input logic v);
    if (inst == 1) cs1 = v;
    else           cs0 = v;
  endtask

  // Called at a negedge while the instance is idle; the next posedge accepts.
  task automatic xfer(input int inst, input bit we, input logic [9:0] addr,
                      input logic [127:0] wd, input bit hold, input bit scramble);
    int lat;
    logic [127:0] prev;
    lat       = (inst == 1) ? 1 : 10;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wd;
    set_cs(inst, 1'b1);
    prev = last_rd[inst];
    @(posedge clk);
    if (we) mdl[inst][addr] = wd;
    else    last_rd[inst]   = mdl[inst][addr];
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk($sformatf("busy%0d_k%0d", inst, k), {127'b0, (inst == 1) ? busy1 : busy0},
          {127'b0, k <= lat});
      chk($sformatf("ack%0d_k%0d", inst, k), {127'b0, (inst == 1) ? ack1 : ack0},
          {127'b0, k == lat});
      chk($sformatf("rdata%0d_k%0d", inst, k), (inst == 1) ? rdata1 : rdata0,
          (k >= lat) ? last_rd[inst] : prev);
      if (!hold) begin
        if (scramble && k < lat) begin
          mem_we    = 1'($urandom);
          mem_addr  = addr + 10'(k);
          mem_wdata = {$urandom, $urandom, $urandom, $urandom};
          set_cs(inst, 1'($urandom));
        end else begin
          set_cs(inst, 1'b0);
        end
      end
    end
  endtask

  function automatic logic [127:0] rline();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] pre10;
    logic [9:0]   a;
    rst = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;

    // reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_ack", {127'b0, ack0}, 128'd0);
      chk("rst_busy", {127'b0, busy0}, 128'd0);
      chk("rst_rdata", rdata0, 128'd0);
    end
    chk("rst_rdata1", rdata1, 128'd0);

    // write then read
    xfer(0, 1'b1, 10'h03A, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0, 1'b0);
    xfer(0, 1'b0, 10'h03A, '0, 1'b0, 1'b0);

    // back-to-back with mem_cs held high, top/bottom addresses
    xfer(0, 1'b1, 10'h000, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0);
    xfer(0, 1'b1, 10'h3FF, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999, 1'b1, 1'b0);
    xfer(0, 1'b0, 10'h000, '0, 1'b1, 1'b0);
    xfer(0, 1'b0, 10'h3FF, '0, 1'b1, 1'b0);
    xfer(0, 1'b1, 10'h000, rline(), 1'b1, 1'b0);
    xfer(0, 1'b0, 10'h3FF, '0, 1'b1, 1'b0);
    xfer(0, 1'b0, 10'h000, '0, 1'b1, 1'b0);
    cs0 = 1'b0;

    // inputs changing while busy
    for (int i = 0; i < 10; i++) xfer(0, 1'b1, 10'h020 + 10'(i), rline(), 1'b0, 1'b0);
    xfer(0, 1'b1, 10'h020, rline(), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) xfer(0, 1'b0, 10'h020 + 10'(i), '0, 1'b0, 1'b0);

    // randomized mix against the model
    for (int i = 0; i < 24; i++) begin
      if (pool.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = 10'($urandom_range(16'h040, 16'h3F0));
        pool.push_back(a);
        xfer(0, 1'b1, a, rline(), 1'b0, 1'($urandom));
      end else begin
        a = pool[$urandom_range(0, pool.size() - 1)];
        xfer(0, 1'b0, a, '0, 1'b0, 1'($urandom));
      end
    end

    // LATENCY=1 instance
    xfer(1, 1'b1, 10'h015, rline(), 1'b0, 1'b0);
    xfer(1, 1'b0, 10'h015, '0, 1'b0, 1'b0);
    xfer(1, 1'b1, 10'h3FF, rline(), 1'b1, 1'b0);
    xfer(1, 1'b0, 10'h3FF, '0, 1'b1, 1'b0);
    xfer(1, 1'b0, 10'h015, '0, 1'b1, 1'b0);
    cs1 = 1'b0;

    // reset during a write
    pre10 = rline();
    xfer(0, 1'b1, 10'h010, pre10, 1'b0, 1'b0);
    xfer(0, 1'b0, 10'h3A, '0, 1'b0, 1'b0);
    mem_we = 1'b1; mem_addr = 10'h010; mem_wdata = ~pre10; cs0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cs0 = 1'b0;
      chk("mrst_busy", {127'b0, busy0}, 128'd1);
      chk("mrst_ack", {127'b0, ack0}, 128'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 12; i++) begin
      chk("mrst_noack", {127'b0, ack0}, 128'd0);
      chk("mrst_idle", {127'b0, busy0}, 128'd0);
      chk("mrst_rdata", rdata0, 128'd0);
      @(negedge clk);
    end
    chk("mrst_rdata1", rdata1, 128'd0);
    xfer(0, 1'b0, 10'h010, '0, 1'b0, 1'b0);
    xfer(0, 1'b0, 10'h000, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
